// File: rtl/aes_result_fifo.sv
// -----------------------------------------------------------------------------
// aes_result_fifo
//
// Result buffer between the AES core and the AHB master in the CCM datapath.
// Each 128-bit AES result is captured on wr_en (aes_done) together with its
// last-packet flag and presented first-word-fall-through on rd_data/rd_last.
// The AHB master pops only when its write beat completes, so bus stalls never
// lose results. Overflow/underflow attempts are recorded in sticky flags that
// the CCU can inspect and clear with the synchronous clear input.
//
// Optional feature macro: CCM_RFIFO_ALMOST_FULL_EN
//   When defined, adds the almost_full output (count >= DEPTH-1), taken from
//   the registered count, so the CCU can stop issuing AES blocks early.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   clear        synchronous flush: empties FIFO, clears sticky flags
//   wr_en        push strobe (aes_done)
//   wr_data      AES result word
//   wr_last      word belongs to the last packet of the transfer
//   rd_en        pop strobe (AHB write beat accepted)
//   rd_data      head entry data (don't-care while empty)
//   rd_last      head entry last flag (don't-care while empty)
//   empty        no valid entry
//   full         count == DEPTH
//   count        number of stored entries, 0..DEPTH
//   overflow     sticky: push attempted while full and not popped
//   underflow    sticky: pop attempted while empty
//   almost_full  count >= DEPTH-1 (only with CCM_RFIFO_ALMOST_FULL_EN)
// -----------------------------------------------------------------------------
module aes_result_fifo #(
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [127:0]      wr_data,
    input  logic              wr_last,
    input  logic              rd_en,
    output logic [127:0]      rd_data,
    output logic              rd_last,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
`ifdef CCM_RFIFO_ALMOST_FULL_EN
    output logic              almost_full,
`endif
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Each entry is {last, data}.
    logic [128:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic              push;
    logic              pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // A push into a full FIFO is still accepted when the head is popped in
    // the same cycle: the freed slot is the one being written. There is no
    // bypass, so a pop on an empty FIFO is never rescued by a same-cycle push.
    assign push = wr_en && (!full || rd_en);
    assign pop  = rd_en && !empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            // Flush only moves pointers; stale array contents stay in place.
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= {wr_last, wr_data};
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // First-word-fall-through: head entry read straight from the array.
    assign rd_data = mem[rp][127:0];
    assign rd_last = mem[rp][128];

`ifdef CCM_RFIFO_ALMOST_FULL_EN
    assign almost_full = (count >= DEPTH_C - 1'b1);
`endif

endmodule

// File: doc/aes_result_fifo.md
# aes_result_fifo

Result buffer between the AES core and the AHB master in the CCM datapath. Captures each 128-bit `data_out` word on `aes_done`, tagged with the `last_packet` flag, and presents it first-word-fall-through to the AHB master. The AHB master pops the word only once its write beat completes, so bus stalls never drop AES results. Overflow and underflow are recorded in sticky error flags for the CCU.

## Interface
Parameters:
- DEPTH, 4, number of 129-bit entries; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush; empties FIFO, clears sticky flags
- wr_en  input  1  push strobe (driven by aes_done)
- wr_data  input  128  AES result word
- wr_last  input  1  word belongs to last packet of the transfer
- rd_en  input  1  pop strobe (AHB master beat accepted)
- rd_data  output  128  head entry data
- rd_last  output  1  head entry last flag
- empty  output  1  no valid entry; rd_data/rd_last are don't-care
- full  output  1  count == DEPTH
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH
- overflow  output  1  sticky: push attempted while full and not popped
- underflow  output  1  sticky: pop attempted while empty
- almost_full  output  1  only with CCM_RFIFO_ALMOST_FULL_EN (see Configuration)

Clock and reset: one clock; reset is asynchronous and active-low (clk, n_rst).

## Operation
- Storage: DEPTH × 129-bit register array {last, data}, write pointer wp, read pointer rp (ADDR_W bits each, wrap modulo DEPTH), count register.
- Push accepted when wr_en && (!full || rd_en): entry[wp] ← {wr_last, wr_data}; wp++.
- Push with wr_en && full && !rd_en: word dropped; overflow ← 1; pointers unchanged.
- Pop accepted when rd_en && !empty: rp++.
- Pop with rd_en && empty: ignored; underflow ← 1. This applies even when wr_en is high in the same cycle, because there is no same-cycle bypass.
- count: +1 on push-only, −1 on pop-only, unchanged on push+pop or neither.
- Outputs: rd_data/rd_last = entry[rp] (combinational read of the registered array); empty = (count == 0); full = (count == DEPTH).
- clear: has priority over wr_en/rd_en. Sets wp = rp = count = 0 and overflow = underflow = 0. Array contents are not zeroed.
- Reset values: wp = rp = count = 0; array zeroed; rd_data = 0; rd_last = 0; empty = 1; full = 0; overflow = 0; underflow = 0; almost_full = 0.
- Reset mid-operation: all contents are discarded immediately (asynchronous). Any half-written packet is lost and the CCU must restart the operation.

## Timing
- Push at edge N: empty deasserts and rd_data is valid in the cycle after edge N (1-cycle latency).
- Pop at edge N: the next entry, or empty = 1, is visible after edge N.
- Full-with-push+pop: both complete at the same edge; count stays DEPTH; no overflow.
- Flags update on the same edge as the offending strobe and hold until clear or reset.
- No combinational path from wr_* to rd_*/empty/full.

## Configuration
- CCM_RFIFO_ALMOST_FULL_EN defined:
  - almost_full output port exists, driven as almost_full = (count ≥ DEPTH−1), from registered count.
  - The CCU uses it to hold start_op and stop issuing AES blocks before the FIFO fills.
- Undefined: port and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then single push of wr_data=128'hDEAD_BEEF…, wr_last=0 → next cycle empty=0, count=1, rd_data=DEAD_BEEF…; pop → empty=1, count=0.
- Four pushes with data 1,2,3,4 (DEPTH=4), last only on 4 → full=1; four pops return 1,2,3,4 in order with rd_last=1 only on 4; pointers wrap and a fifth push/pop round-trip returns the correct word.
- Full FIFO: wr_en alone → overflow=1, count=4, contents unchanged; then wr_en+rd_en together → count=4, no change to overflow, head advances by one.
- Empty FIFO: rd_en → underflow=1, count=0; wr_en+rd_en same cycle → count=1, underflow set.
- Assert clear with count=3 and both flags set → next cycle count=0, empty=1, overflow=0, underflow=0. Pull n_rst low mid-burst → all outputs at reset values asynchronously.
- With CCM_RFIFO_ALMOST_FULL_EN: almost_full=0 at count=2, 1 at count=3 and 4, back to 0 after a pop to count=2.
